// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte strobes of the UART receiver
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            i_rx;
    logic [DBIT-1:0] o_rx_data;
    logic            os_rx_done;
    logic            os_frame_err;

    modport master (
        input  i_rx,
        output o_rx_data,
        output os_rx_done,
        output os_frame_err
    );

    modport slave (
        output i_rx,
        input  o_rx_data,
        input  os_rx_done,
        input  os_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with frame-error and break handling
module uart_rx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_s, w_s_nxt;
    logic [NW-1:0]   r_n, w_n_nxt;
    logic [DBIT-1:0] r_sh, w_sh_nxt;
    logic [TW-1:0]   r_tick_cnt;
    logic            r_rx_meta, r_rx_s, r_rx_prev;
    logic [DBIT-1:0] r_rx_data;
    logic            r_done, r_err;
    logic            w_tick, w_done, w_err, w_stop_pt;

    // r_rx_prev is the synchronised line one clock earlier, for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_tick = (r_tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_sh_nxt    = r_sh;
        case (r_state)
            IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!r_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_nxt  = '0;
                        w_sh_nxt = {r_rx_s, r_sh[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) w_state_nxt = STOP;
                        else                      w_n_nxt     = r_n + 1'b1;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) w_state_nxt = r_rx_s ? IDLE : WAIT_HIGH;
                    else                         w_s_nxt     = r_s + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (r_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_stop_pt = (r_state == STOP) && w_tick && (r_s == SW'(SB_TICK - 1));
        w_done    = w_stop_pt && r_rx_s;
        w_err     = w_stop_pt && !r_rx_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
            if (w_done) r_rx_data <= r_sh;
        end
    end

    assign bus.o_rx_data    = r_rx_data;
    assign bus.os_rx_done   = r_done;
    assign bus.os_frame_err = r_err;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at BAUD_DIV = 4 (64 clk per bit)
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          both_hi = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    logic [7:0]  rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.os_rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            rx_q.push_back(bus.o_rx_data);
        end
        if (bus.os_frame_err) err_cnt = err_cnt + 1;
        if (bus.os_rx_done && bus.os_frame_err) both_hi = both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bus.i_rx = b;
        repeat (63) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        bus.i_rx  = 1'b0;
        start_cyc = cyc;
        repeat (63) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    int         base_done, base_err, base_q, lat;
    logic [7:0] d81;

    initial begin
        bus.i_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(bus.o_rx_data), 32'h00);
        check("reset_done", 32'(bus.os_rx_done), 32'h0);
        check("reset_err",  32'(bus.os_frame_err), 32'h0);
        rst = 1'b0;

        repeat (10000) @(negedge clk);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);
        check("idle_err_cnt",  32'(err_cnt), 32'd0);
        check("idle_data",     32'(bus.o_rx_data), 32'h00);

        send_byte(8'hA5, 1'b1);
        repeat (64) @(negedge clk);
        lat = done_cyc - start_cyc;
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_data", 32'(rx_q[0]), 32'hA5);
        check("a5_latency_in_608_620", 32'((lat >= 608) && (lat <= 620)), 32'd1);
        check("a5_err_cnt", 32'(err_cnt), 32'd0);
        check("a5_hold", 32'(bus.o_rx_data), 32'hA5);

        base_q = rx_q.size();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (64) @(negedge clk);
        check("b2b_done_cnt", 32'(done_cnt), 32'd5);
        if (rx_q.size() >= base_q + 4) begin
            check("b2b_byte0", 32'(rx_q[base_q]),   32'hFF);
            check("b2b_byte1", 32'(rx_q[base_q+1]), 32'h00);
            check("b2b_byte2", 32'(rx_q[base_q+2]), 32'hFF);
            check("b2b_byte3", 32'(rx_q[base_q+3]), 32'h00);
            check("b2b_instr", {rx_q[base_q], rx_q[base_q+1], rx_q[base_q+2], rx_q[base_q+3]}, 32'hFF00FF00);
        end else begin
            check("b2b_queue_size", 32'(rx_q.size()), 32'(base_q + 4));
        end

        @(negedge clk);
        bus.i_rx = 1'b0;
        repeat (12) @(negedge clk);
        bus.i_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_done_cnt", 32'(done_cnt), 32'd5);
        check("glitch_err_cnt",  32'(err_cnt), 32'd0);
        send_byte(8'h3C, 1'b1);
        repeat (64) @(negedge clk);
        check("after_glitch_done_cnt", 32'(done_cnt), 32'd6);
        check("after_glitch_data", 32'(bus.o_rx_data), 32'h3C);

        send_byte(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_err_cnt",  32'(err_cnt), 32'd1);
        check("ferr_done_cnt", 32'(done_cnt), 32'd6);
        check("ferr_data_kept", 32'(bus.o_rx_data), 32'h3C);
        bus.i_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("break_release_done_cnt", 32'(done_cnt), 32'd6);
        check("break_release_err_cnt",  32'(err_cnt), 32'd1);

        d81 = 8'h81;
        base_done = done_cnt;
        base_err  = err_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d81[i]);
        @(negedge clk);
        bus.i_rx = d81[4];
        repeat (32) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(bus.o_rx_data), 32'h00);
        check("midrst_done", 32'(bus.os_rx_done), 32'h0);
        check("midrst_err",  32'(bus.os_frame_err), 32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        bus.i_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt), 32'(base_done));
        check("midrst_no_err",  32'(err_cnt), 32'(base_err));
        send_byte(8'h7E, 1'b1);
        repeat (64) @(negedge clk);
        check("after_rst_done_cnt", 32'(done_cnt), 32'(base_done + 1));
        check("after_rst_data", 32'(bus.o_rx_data), 32'h7E);

        check("never_both_strobes", 32'(both_hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame, LSB first.
REQ-002 Parameter SB_TICK, default 16: oversample ticks spanning the stop bit.
REQ-003 Parameter BAUD_DIV, default 163: clocks per 16x oversample tick (50 MHz, 19200 baud).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  system clock, all logic on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: i_rx  input  1  serial line; idles high; asynchronous to clk.
REQ-008 Port: o_rx_data  output  DBIT  last correctly framed byte; feeds the load FSM's i_rx_data.
REQ-009 Port: os_rx_done  output  1  one-clock strobe, o_rx_data valid; feeds the load FSM's is_rx_done.
REQ-010 Port: os_frame_err  output  1  one-clock strobe, stop bit sampled low.

Function
REQ-011 i_rx SHALL pass a 2-flop synchroniser; all decisions use the synchronised value (rx_s); rx_s resets to 1.
REQ-012 Free-running tick counter 0..BAUD_DIV-1; internal tick high for one clock when count = BAUD_DIV-1; the counter then wraps to 0.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; reset state IDLE.
REQ-014 IDLE: falling edge on rx_s (previous 1, current 0) -> START, oversample count s cleared to 0; rx_s held low without a falling edge SHALL NOT start a frame.
REQ-015 START: count ticks; at s = 7 (mid start bit), rx_s = 0 -> DATA with s = 0 and bit count n = 0; rx_s = 1 -> IDLE (glitch reject, no strobe).
REQ-016 DATA: at s = 15, shift rx_s into the MSB of the shift register (right shift, LSB first) and clear s; after bit n = DBIT-1 is sampled -> STOP.
REQ-017 STOP: at s = SB_TICK-1, rx_s = 1 -> load o_rx_data from the shift register, pulse os_rx_done, go to IDLE.
REQ-018 STOP: at s = SB_TICK-1, rx_s = 0 -> pulse os_frame_err, leave o_rx_data unchanged, no os_rx_done, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rx_s = 1, then IDLE; this covers the break condition.
REQ-020 o_rx_data SHALL change only in the cycle os_rx_done is asserted and hold its value until the next valid frame.
REQ-021 os_rx_done and os_frame_err SHALL be registered, high for exactly one clk, and never both high in the same cycle.
REQ-022 Latency: os_rx_done asserts 8 + 16*DBIT + SB_TICK ticks (+0..BAUD_DIV+3 clocks of tick phase and synchroniser) after the i_rx falling edge.
REQ-023 Back-to-back frames with a single stop bit SHALL be received without loss; IDLE re-arms in the cycle after the strobe.
REQ-024 The tick counter SHALL run independently of FSM state and is not re-phased on start detection.

Reset
REQ-025 rst = 1 SHALL immediately force: state IDLE, s = 0, n = 0, shift register = 0, tick counter = 0, synchroniser = 1, o_rx_data = 0, os_rx_done = 0, os_frame_err = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, reception resumes only on a fresh falling edge.

Verification (bench runs BAUD_DIV = 4: bit period = 64 clk)
REQ-027 Single frame 0xA5, 1 stop bit -> exactly one os_rx_done pulse; o_rx_data = 0xA5 in that cycle; pulse 608-620 clk after the falling edge; os_frame_err stays 0.
REQ-028 Four back-to-back frames 0xFF, 0x00, 0xFF, 0x00 -> four os_rx_done pulses with matching o_rx_data; with the load FSM attached, it emits instruction 0xFF00FF00 (or its byte-order equivalent) and os_WriteMem.
REQ-029 Low glitch of 3 tick periods (12 clk) on an idle line -> no strobe; FSM back in IDLE; the next valid frame 0x3C is received correctly.
REQ-030 Frame 0x55 with stop bit driven 0, then line held low 200 clk, then released high -> one os_frame_err pulse, no os_rx_done, o_rx_data keeps its previous value, no new frame starts while the line is low.
REQ-031 rst pulsed during data bit 4 of frame 0x81 -> all outputs 0 immediately; no strobe for the aborted frame; the following frame 0x7E yields o_rx_data = 0x7E.
REQ-032 Idle line high for 10000 clk after reset -> os_rx_done = os_frame_err = 0 throughout; o_rx_data = 0x00.
